spike_rate_encoder: RTL and testbench
=====================================

# spike_rate_encoder

Rate-codes a vector of pixel intensities into per-timestep spike trains that drive the `spike_in` inputs of a layer of leaky-integrate-fire neurons, one channel per neuron. A frame is accepted over a valid/ready handshake. The block then emits one spike decision per channel on each timestep tick, for a fixed window of timesteps. Two coding modes are supported: stochastic (per-channel LFSR compare) and deterministic (phase accumulator).

## Interface
Parameters:
- `N_CH`, 4: number of channels (neurons driven).
- `PIX_W`, 8: intensity width per channel, unsigned.
- `WIN_LEN`, 100: timesteps per frame window, must be ≥1.
- `SEED`, 16'hACE1: base LFSR seed.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pixel_data`  in  N_CH*PIX_W  intensities; channel i occupies bits [i*PIX_W +: PIX_W].
- `pixel_mode`  in  1  0 = stochastic, 1 = deterministic; sampled with the frame.
- `pixel_valid`  in  1  frame offered.
- `pixel_ready`  out  1  block can accept a frame.
- `step_en`  in  1  timestep tick (one-cycle pulse from the network scheduler).
- `abort`  in  1  terminate the current window.
- `spike_out`  out  N_CH  per-channel spike, one-cycle pulse.
- `busy`  out  1  window in progress.
- `window_done`  out  1  one-cycle pulse with the last timestep's spikes.

## Operation
- FSM states: IDLE, RUN.
- IDLE:
  - `pixel_ready`=1.
  - On `pixel_valid && pixel_ready`: latch `pixel_data` and `pixel_mode`, clear all accumulators, clear `step_cnt`, and reload the LFSRs. Go to RUN.
- RUN:
  - `pixel_ready`=0, `busy`=1. `pixel_valid` is ignored.
  - Each `step_en` cycle evaluates all channels and increments `step_cnt`. Cycles without `step_en` hold all state.
- LFSRs:
  - One 16-bit Fibonacci LFSR per channel, polynomial x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  - Channel i is seeded with `SEED ^ i`. If that value is 0, seed with 16'hACE1.
  - Each LFSR advances once per `step_en` in RUN, in both modes.
- Stochastic mode: `rnd_i` = LFSR_i[PIX_W-1:0], taken before the advance. `spike_i` = (`rnd_i` < `I_i`), unsigned compare.
  - `I`=0 never spikes.
  - `I`=2^PIX_W−1 spikes on every step except when `rnd` equals all-ones.
- Deterministic mode: `sum` = `acc_i` + `I_i`, computed PIX_W+1 bits wide.
  - `spike_i` = `sum[PIX_W]` (the carry).
  - `acc_i` <= `sum[PIX_W-1:0]`.
  - Resulting spike count over K steps = floor(K*I/2^PIX_W).
- `step_cnt` width is $clog2(WIN_LEN+1).
  - A `step_en` with `step_cnt`==WIN_LEN−1 is the last step: assert `window_done` with that step's spikes, then return to IDLE.
- `abort` in RUN: return to IDLE next cycle; no spikes, no `window_done`. `abort` in IDLE is ignored.
- `reset` mid-window: all state cleared, same as power-up reset. The partial window is discarded.

## Timing
- Reset values:
  - `spike_out`=0, `window_done`=0, `busy`=0.
  - State=IDLE, accumulators=0, `step_cnt`=0, LFSRs=seeds.
  - `pixel_ready`=0 while `reset` is high; it is 1 the first cycle after `reset` falls.
- Accept cycle T: `busy`=1 and `pixel_ready`=0 from T+1.
  - A `step_en` in cycle T itself is not counted.
  - The first countable `step_en` is at T+1.
- Spike latency: a `step_en` at cycle t produces a registered `spike_out` and `window_done` at t+1, valid for exactly that one cycle. `spike_out`=0 in every other cycle.
- Last step at cycle t:
  - `busy`=0 and `pixel_ready`=1 at t+1, the same cycle as `window_done`.
  - A new frame can be accepted at t+1. Back-to-back windows are supported.
- `abort` and `step_en` in the same cycle: `abort` wins; no spike is produced and the step is not counted.
- `abort` at t: `busy`=0 and `pixel_ready`=1 at t+1.
- Back-to-back `step_en` (every cycle) is legal at full rate.

## Test plan
- **Deterministic rate.** Setup: WIN_LEN=8, mode=1, intensities {0, 64, 128, 255}, `step_en` every cycle.
  - ch0: 0 spikes.
  - ch1: spikes on steps 4 and 8.
  - ch2: spikes on steps 2, 4, 6, 8.
  - ch3: spikes on steps 2–8 (7 spikes).
  - `window_done` on step 8's output cycle.
- **Stochastic statistics.** Setup: mode=0, WIN_LEN=100, intensity 128 on all channels.
  - Spike counts match a bit-exact software LFSR model.
  - Each count lies within 35–65.
  - Intensity 0 gives 0 spikes.
- **Handshake and gaps.**
  - `pixel_valid` held high during RUN: no second accept until `window_done`.
  - `step_en` with random gaps: same spike sequence as the gap-free run.
  - Accept at the `window_done` cycle: the new window starts immediately.
- **Abort.** Setup: abort at step 3 of 8.
  - No further spikes, no `window_done`.
  - `pixel_ready`=1 next cycle.
  - With `abort` and `step_en` coincident: no spike.
- **Reset mid-window.** Assert `reset` at step 5.
  - All outputs are 0 and `pixel_ready`=0 during reset.
  - After release, a fresh frame reproduces the step-1 spike sequence exactly (LFSRs reseeded).
- **Latency.** For each `step_en` at cycle t:
  - `spike_out` is asserted only at t+1.
  - No `step_en` → `spike_out`=0 in all modes.

Source files
------------

// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
// Rate-codes a frame of pixel intensities into per-timestep spike trains, one
// channel per downstream leaky-integrate-fire neuron. A frame is taken over a
// valid/ready handshake, after which every step_en tick produces one spike
// decision per channel until WIN_LEN ticks have been consumed.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   pixel_data   in   N_CH*PIX_W intensities, channel i at [i*PIX_W +: PIX_W]
//   pixel_mode   in   0 = stochastic (LFSR compare), 1 = deterministic (accumulator)
//   pixel_valid  in   frame offered
//   pixel_ready  out  frame can be accepted (IDLE and not in reset)
//   step_en      in   timestep tick
//   abort        in   terminate the current window
//   spike_out    out  per-channel spike, one-cycle pulse after the tick
//   busy         out  window in progress
//   window_done  out  one-cycle pulse alongside the last timestep's spikes
module spike_rate_encoder #(
  parameter int          N_CH    = 4,
  parameter int          PIX_W   = 8,
  parameter int          WIN_LEN = 100,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH*PIX_W-1:0]   pixel_data,
  input  logic                    pixel_mode,
  input  logic                    pixel_valid,
  output logic                    pixel_ready,
  input  logic                    step_en,
  input  logic                    abort,
  output logic [N_CH-1:0]         spike_out,
  output logic                    busy,
  output logic                    window_done
);

  localparam int             CNT_W = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIN_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic             r_mode;
  logic [CNT_W-1:0] r_step_cnt;
  logic [N_CH-1:0]  r_spike;
  logic             r_done;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [N_CH-1:0]  w_spike;

  // abort outranks step_en: a coincident tick is neither counted nor spiked.
  assign w_accept = (r_state == IDLE) && pixel_valid;
  assign w_step   = (r_state == RUN) && step_en && !abort;
  assign w_last   = (r_step_cnt == LAST_STEP);

  // Gated by reset so a frame cannot be offered a ready while reset is held.
  assign pixel_ready = (r_state == IDLE) && !reset;
  assign busy        = (r_state == RUN);
  assign spike_out   = r_spike;
  assign window_done = r_done;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      // An all-zero seed would lock the LFSR, so fall back to the default.
      localparam logic [15:0] SEED_RAW = SEED ^ 16'(gi);
      localparam logic [15:0] SEED_CH  = (SEED_RAW == 16'h0000) ? 16'hACE1 : SEED_RAW;

      logic [PIX_W-1:0] r_pix;
      logic [PIX_W-1:0] r_acc;
      logic [15:0]      r_lfsr;
      logic [PIX_W:0]   w_sum;
      logic             w_fb;
      logic             w_rnd_hit;

      // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0.
      assign w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
      assign w_sum     = {1'b0, r_acc} + {1'b0, r_pix};
      assign w_rnd_hit = (r_lfsr[PIX_W-1:0] < r_pix);
      // Deterministic mode spikes on accumulator overflow.
      assign w_spike[gi] = r_mode ? w_sum[PIX_W] : w_rnd_hit;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_pix  <= '0;
          r_acc  <= '0;
          r_lfsr <= SEED_CH;
        end else if (w_accept) begin
          r_pix  <= pixel_data[gi*PIX_W +: PIX_W];
          r_acc  <= '0;
          r_lfsr <= SEED_CH;
        end else if (w_step) begin
          // The LFSR advances in both modes so its phase tracks the step count.
          r_lfsr <= {r_lfsr[14:0], w_fb};
          if (r_mode) begin
            r_acc <= w_sum[PIX_W-1:0];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mode     <= 1'b0;
      r_step_cnt <= '0;
      r_spike    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_spike <= w_step ? w_spike : '0;
      r_done  <= w_step && w_last;
      case (r_state)
        IDLE: begin
          if (pixel_valid) begin
            r_mode     <= pixel_mode;
            r_step_cnt <= '0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
          end else if (step_en) begin
            if (w_last) begin
              r_step_cnt <= '0;
              r_state    <= IDLE;
            end else begin
              r_step_cnt <= r_step_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
module tb_spike_rate_encoder;

  logic        clk = 1'b0;
  logic        reset;

  // Short-window instance (WIN_LEN = 8)
  logic [31:0] pixel_data;
  logic        pixel_mode, pixel_valid, pixel_ready, step_en, abort;
  logic [3:0]  spike_out;
  logic        busy, window_done;

  // Long-window instance (WIN_LEN = 100) for the stochastic statistics
  logic [31:0] l_data;
  logic        l_mode, l_valid, l_ready, l_step, l_abort;
  logic [3:0]  l_spike;
  logic        l_busy, l_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_lfsr [4];
  logic [7:0]  m_pix  [4];
  logic [3:0]  m_sp;
  logic [3:0]  det_exp [8];
  int          cnt_obs [4];
  int          cnt_mod [4];
  int          ch1_cnt;

  spike_rate_encoder #(.N_CH(4), .PIX_W(8), .WIN_LEN(8), .SEED(16'hACE1)) u_dut (
    .clk(clk), .reset(reset), .pixel_data(pixel_data), .pixel_mode(pixel_mode),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .step_en(step_en),
    .abort(abort), .spike_out(spike_out), .busy(busy), .window_done(window_done)
  );

  spike_rate_encoder #(.N_CH(4), .PIX_W(8), .WIN_LEN(100), .SEED(16'hACE1)) u_dut100 (
    .clk(clk), .reset(reset), .pixel_data(l_data), .pixel_mode(l_mode),
    .pixel_valid(l_valid), .pixel_ready(l_ready), .step_en(l_step),
    .abort(l_abort), .spike_out(l_spike), .busy(l_busy), .window_done(l_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic m_load(input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      m_pix[i]  = d[i*8 +: 8];
      m_lfsr[i] = 16'hACE1 ^ 16'(i);
    end
  endtask

  task automatic m_step(output logic [3:0] sp);
    for (int i = 0; i < 4; i++) begin
      sp[i]     = (m_lfsr[i][7:0] < m_pix[i]);
      m_lfsr[i] = lfsr_adv(m_lfsr[i]);
    end
  endtask

  initial begin
    det_exp = '{4'h0, 4'hC, 4'h8, 4'hE, 4'h8, 4'hC, 4'h8, 4'hE};
    reset = 1'b1; pixel_data = '0; pixel_mode = 1'b0; pixel_valid = 1'b0;
    step_en = 1'b0; abort = 1'b0;
    l_data = '0; l_mode = 1'b0; l_valid = 1'b0; l_step = 1'b0; l_abort = 1'b0;

    // ---- reset state
    repeat (3) tick();
    chk("rst_spike", 32'(spike_out), 0);
    chk("rst_done", 32'(window_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(pixel_ready), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(pixel_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);

    // ---- deterministic rate, step_en every cycle (tick in accept cycle ignored)
    pixel_data = {8'd255, 8'd128, 8'd64, 8'd0};
    pixel_mode = 1'b1; pixel_valid = 1'b1; step_en = 1'b1;
    tick();
    chk("acc_busy", 32'(busy), 1);
    chk("acc_ready", 32'(pixel_ready), 0);
    chk("acc_spike", 32'(spike_out), 0);
    pixel_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("det_s%0d", k + 1), 32'(spike_out), 32'(det_exp[k]));
      chk($sformatf("det_done%0d", k + 1), 32'(window_done), (k == 7) ? 1 : 0);
    end
    chk("det_end_busy", 32'(busy), 0);
    chk("det_end_ready", 32'(pixel_ready), 1);
    step_en = 1'b0;
    tick();
    chk("idle_spike", 32'(spike_out), 0);
    chk("idle_done", 32'(window_done), 0);

    // ---- gaps, pixel_valid held through RUN, back-to-back accept at done
    pixel_valid = 1'b1;
    tick();
    chk("gap_acc_busy", 32'(busy), 1);
    for (int k = 0; k < 8; k++) begin
      step_en = 1'b0;
      for (int g = 0; g < (k % 3); g++) begin
        tick();
        chk("gap_nospike", 32'(spike_out), 0);
        chk("gap_ready", 32'(pixel_ready), 0);
      end
      step_en = 1'b1;
      tick();
      chk($sformatf("gap_s%0d", k + 1), 32'(spike_out), 32'(det_exp[k]));
      chk($sformatf("gap_done%0d", k + 1), 32'(window_done), (k == 7) ? 1 : 0);
    end
    chk("b2b_ready", 32'(pixel_ready), 1);
    step_en = 1'b0;
    tick();
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_spike", 32'(spike_out), 0);
    pixel_valid = 1'b0;

    // ---- abort at step 3, coincident with step_en
    step_en = 1'b1;
    tick();
    chk("ab_s1", 32'(spike_out), 32'(det_exp[0]));
    tick();
    chk("ab_s2", 32'(spike_out), 32'(det_exp[1]));
    abort = 1'b1;
    tick();
    chk("ab_spike", 32'(spike_out), 0);
    chk("ab_done", 32'(window_done), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_ready", 32'(pixel_ready), 1);
    abort = 1'b0;
    repeat (3) begin
      tick();
      chk("ab_after_spike", 32'(spike_out), 0);
      chk("ab_after_done", 32'(window_done), 0);
    end
    step_en = 1'b0;
    // abort in IDLE is ignored: the frame is still accepted
    abort = 1'b1; pixel_valid = 1'b1;
    tick();
    chk("ab_idle_accept", 32'(busy), 1);
    pixel_valid = 1'b0;
    tick();
    chk("ab_nostep_busy", 32'(busy), 0);
    abort = 1'b0;

    // ---- stochastic mode, reset mid-window, reseeded replay
    pixel_data = {8'd37, 8'd255, 8'd0, 8'd128};
    pixel_mode = 1'b0; pixel_valid = 1'b1;
    m_load(pixel_data);
    tick();
    pixel_valid = 1'b0;
    step_en = 1'b1;
    ch1_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      m_step(m_sp);
      chk($sformatf("sto_s%0d", k + 1), 32'(spike_out), 32'(m_sp));
      ch1_cnt += int'(spike_out[1]);
    end
    reset = 1'b1;
    tick();
    chk("mrst_spike", 32'(spike_out), 0);
    chk("mrst_done", 32'(window_done), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ready", 32'(pixel_ready), 0);
    tick();
    chk("mrst_ready2", 32'(pixel_ready), 0);
    reset = 1'b0; step_en = 1'b0;
    tick();
    chk("mrst_rel_ready", 32'(pixel_ready), 1);
    pixel_valid = 1'b1;
    m_load(pixel_data);
    tick();
    pixel_valid = 1'b0;
    step_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      m_step(m_sp);
      chk($sformatf("replay_s%0d", k + 1), 32'(spike_out), 32'(m_sp));
      ch1_cnt += int'(spike_out[1]);
    end
    chk("replay_done", 32'(window_done), 1);
    chk("zero_int_cnt", 32'(ch1_cnt), 0);
    step_en = 1'b0;

    // ---- stochastic statistics over a 100-step window
    l_data = {8'd128, 8'd128, 8'd128, 8'd128};
    l_valid = 1'b1;
    m_load(l_data);
    for (int i = 0; i < 4; i++) begin
      cnt_obs[i] = 0;
      cnt_mod[i] = 0;
    end
    tick();
    l_valid = 1'b0;
    l_step = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      m_step(m_sp);
      chk($sformatf("stat_s%0d", k + 1), 32'(l_spike), 32'(m_sp));
      for (int i = 0; i < 4; i++) begin
        cnt_obs[i] += int'(l_spike[i]);
        cnt_mod[i] += int'(m_sp[i]);
      end
    end
    chk("stat_done", 32'(l_done), 1);
    chk("stat_busy", 32'(l_busy), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stat_cnt%0d", i), 32'(cnt_obs[i]), 32'(cnt_mod[i]));
      chk($sformatf("stat_range%0d", i), 32'((cnt_obs[i] >= 35) && (cnt_obs[i] <= 65)), 1);
    end
    l_step = 1'b0;
    tick();
    chk("stat_idle_spike", 32'(l_spike), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
